// File: rtl/sr_pkg.sv
// Shared types, default constants and the SR excitation rule for the SR bank drivers.
package sr_pkg;

    localparam int unsigned SR_DEF_WIDTH      = 4;
    localparam int unsigned SR_DEF_PULSE_CYC  = 2;
    localparam int unsigned SR_DEF_SETTLE_CYC = 1;
    localparam int unsigned SR_DEF_MAX_RETRY  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } sr_state_e;

    // Returns {S,R} for a single cell moving from q to q_next; refresh drives hold cases too.
    function automatic logic [1:0] sr_excite(input logic q, input logic q_next, input logic refresh);
        logic [1:0] sr;
        sr = 2'b00;
        if (q_next && (!q || refresh)) begin
            sr = 2'b10;
        end else if (!q_next && (q || refresh)) begin
            sr = 2'b01;
        end
        return sr;
    endfunction

endpackage

// File: rtl/sr_excite_calc.sv
// Per-word combinational S/R generator.
// SR_REFRESH_EN: when defined, unchanged bits are also driven (1->1 sets, 0->0 resets).
module sr_excite_calc
    import sr_pkg::*;
#(
    parameter int unsigned WIDTH = SR_DEF_WIDTH
) (
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] s_c,
    output logic [WIDTH-1:0] r_c
);

`ifdef SR_REFRESH_EN
    localparam logic REFRESH = 1'b1;
`else
    localparam logic REFRESH = 1'b0;
`endif

    // Apply the excitation rule bit by bit; S and R are mutually exclusive by construction.
    always_comb begin
        s_c = '0;
        r_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            {s_c[i], r_c[i]} = sr_excite(q[i], target[i], REFRESH);
        end
    end

endmodule

// File: rtl/sr_excitation_driver.sv
// Write-side controller for a bank of external SR flip-flops: pulse, settle, read back, retry.
// Optional macro SR_REFRESH_EN (handled in sr_excite_calc) actively refreshes unchanged bits.
module sr_excitation_driver
    import sr_pkg::*;
#(
    parameter int unsigned WIDTH      = SR_DEF_WIDTH,
    parameter int unsigned PULSE_CYC  = SR_DEF_PULSE_CYC,
    parameter int unsigned SETTLE_CYC = SR_DEF_SETTLE_CYC,
    parameter int unsigned MAX_RETRY  = SR_DEF_MAX_RETRY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_target,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] sr_s,
    output logic [WIDTH-1:0] sr_r,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned CNT_MAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned RTY_W   = 4;

    sr_state_e        state;
    logic [WIDTH-1:0] target;
    logic [CNT_W-1:0] cyc_cnt;
    logic [RTY_W-1:0] retry_cnt;
    logic [WIDTH-1:0] calc_target;
    logic [WIDTH-1:0] s_c;
    logic [WIDTH-1:0] r_c;
    logic             accept_c;

    // In IDLE the incoming word is excited directly; afterwards the captured target is used.
    assign calc_target = (state == ST_IDLE) ? in_target : target;
    assign accept_c    = (state == ST_IDLE) && in_ready && in_valid;

    sr_excite_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .target (calc_target),
        .q      (q_fb),
        .s_c    (s_c),
        .r_c    (r_c)
    );

    // Write sequencer: accept, pulse, settle, check, retry or finish; all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            target    <= '0;
            cyc_cnt   <= '0;
            retry_cnt <= '0;
            sr_s      <= '0;
            sr_r      <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    sr_s <= '0;
                    sr_r <= '0;
                    if (accept_c) begin
                        target    <= in_target;
                        retry_cnt <= '0;
                        cyc_cnt   <= '0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        if ((s_c | r_c) != '0) begin
                            sr_s  <= s_c;
                            sr_r  <= r_c;
                            state <= ST_PULSE;
                        end else begin
                            state <= ST_CHECK;
                        end
                    end else begin
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                ST_PULSE: begin
                    if (cyc_cnt == CNT_W'(PULSE_CYC - 1)) begin
                        sr_s    <= '0;
                        sr_r    <= '0;
                        cyc_cnt <= '0;
                        state   <= ST_SETTLE;
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (cyc_cnt == CNT_W'(SETTLE_CYC - 1)) begin
                        cyc_cnt <= '0;
                        state   <= ST_CHECK;
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (q_fb == target) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (retry_cnt < RTY_W'(MAX_RETRY)) begin
                        retry_cnt <= retry_cnt + RTY_W'(1);
                        sr_s      <= s_c;
                        sr_r      <= r_c;
                        cyc_cnt   <= '0;
                        state     <= ST_PULSE;
                    end else begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_excitation_driver.sv
// Self-checking bench for sr_excitation_driver with a behavioural SR bank and write model.
module tb_sr_excitation_driver;

    localparam int unsigned W = 4;
    localparam int unsigned P = 2;
    localparam int unsigned S = 1;
    localparam int unsigned R = 3;
`ifdef SR_REFRESH_EN
    localparam bit REFRESH = 1'b1;
`else
    localparam bit REFRESH = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_target = '0;
    logic [W-1:0] q_fb;
    logic [W-1:0] sr_s;
    logic [W-1:0] sr_r;
    logic         busy;
    logic         done;
    logic         err;

    logic [W-1:0] bank  = '0;
    logic [W-1:0] stuck = '0;

    int checks = 0;
    int errors = 0;

    sr_excitation_driver #(
        .WIDTH      (W),
        .PULSE_CYC  (P),
        .SETTLE_CYC (S),
        .MAX_RETRY  (R)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_target (in_target),
        .q_fb      (q_fb),
        .sr_s      (sr_s),
        .sr_r      (sr_r),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // SR bank: each cell sets on S, resets on R, holds otherwise; stuck bits read 0.
    always @(posedge clk) begin
        bank <= ((bank | sr_s) & ~sr_r) & ~stuck;
    end
    assign q_fb = bank;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected outcome of one write from first principles: excite, apply, compare, retry.
    task automatic ref_model(input logic [W-1:0] q_start, input logic [W-1:0] t,
                             input logic [W-1:0] stk, output bit ok, output int lat,
                             output int att, output logic [W-1:0] s0, output logic [W-1:0] r0);
        logic [W-1:0] q;
        logic [W-1:0] s;
        logic [W-1:0] r;
        q   = q_start;
        att = 0;
        s   = REFRESH ? t  : (t & ~q);
        r   = REFRESH ? ~t : (~t & q);
        s0  = s;
        r0  = r;
        if ((s | r) == '0) begin
            ok  = 1'b1;
            lat = 2;
        end else begin
            for (int a = 0; a <= int'(R); a++) begin
                att++;
                q = ((q | s) & ~r) & ~stk;
                if (q == t) break;
                s = REFRESH ? t  : (t & ~q);
                r = REFRESH ? ~t : (~t & q);
            end
            ok  = (q == t);
            lat = 1 + att * int'(P + S + 1);
        end
    endtask

    task automatic do_write(input logic [W-1:0] t, input bit hold);
        logic [W-1:0] es0, er0, fs, fr;
        bit eok, got_done, got_err, seen, prev_nz, cur_nz, bad_ovl, bad_rdy, bad_busy;
        int elat, eatt, lat, starts, pcyc, n;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(n < 20), 32'd1);
        ref_model(bank, t, stuck, eok, elat, eatt, es0, er0);
        in_valid = 1'b1;
        in_target = t;
        @(posedge clk);
        #1;
        if (hold) in_target = W'($urandom);
        else in_valid = 1'b0;
        got_done = 0; got_err = 0; seen = 0; prev_nz = 0;
        bad_ovl = 0; bad_rdy = 0; bad_busy = 0;
        lat = 0; starts = 0; pcyc = 0; fs = '0; fr = '0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            cur_nz = |(sr_s | sr_r);
            if ((sr_s & sr_r) != '0) bad_ovl = 1;
            if (in_ready !== 1'b0) bad_rdy = 1;
            if (cur_nz && !prev_nz) starts++;
            if (cur_nz && !seen) begin
                seen = 1; fs = sr_s; fr = sr_r;
            end
            if (cur_nz) pcyc++;
            prev_nz = cur_nz;
            if (done === 1'b1 || err === 1'b1) begin
                if (busy !== 1'b0) bad_busy = 1;
                lat = c; got_done = done; got_err = err;
                in_valid = 1'b0;
                break;
            end
            if (busy !== 1'b1) bad_busy = 1;
            if (hold) in_target = W'($urandom);
        end
        chk("result", {30'd0, got_done, got_err}, eok ? 32'd2 : 32'd1);
        chk("latency", 32'(lat), 32'(elat));
        chk("pulse_count", 32'(starts), 32'(eatt));
        chk("pulse_cycles", 32'(pcyc), 32'(eatt * int'(P)));
        chk("first_s", 32'(fs), 32'(es0));
        chk("first_r", 32'(fr), 32'(er0));
        chk("no_s_and_r", 32'(bad_ovl), 32'd0);
        chk("ready_low_busy", 32'(bad_rdy), 32'd0);
        chk("busy_shape", 32'(bad_busy), 32'd0);
        if (eok) chk("bank_value", 32'(bank), 32'(t));
        @(negedge clk);
        chk("one_cycle_pulse", {30'd0, done, err}, 32'd0);
        chk("ready_after", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] es0, er0;
        bit eok, bad;
        int elat, eatt;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_outs", {24'd0, sr_s, sr_r}, 32'd0);
        chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        // Directed writes
        do_write(4'b1010, 1'b0);
        do_write(4'b0110, 1'b0);
        do_write(4'b0110, 1'b0);

        // Stuck-at-0 on bit0
        stuck = 4'b0001;
        do_write(4'b0001, 1'b0);
        stuck = '0;

        // Busy with in_valid held and changing targets
        do_write(4'b1100, 1'b1);
        do_write(4'b0011, 1'b1);

        // Reset in the middle of a pulse
        @(negedge clk);
        ref_model(bank, 4'b1111, stuck, eok, elat, eatt, es0, er0);
        in_valid = 1'b1;
        in_target = 4'b1111;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_pulse_s", 32'(sr_s), 32'(es0));
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_drop", {24'd0, sr_s, sr_r}, 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0) bad = 1;
        end
        chk("quiet_in_reset", 32'(bad), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_mid_rst", 32'(in_ready), 32'd1);
        do_write(4'b1111, 1'b0);

        // Randomized writes, occasional stuck-at-0 cells on currently-zero bits
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(3) == 0) stuck = W'($urandom) & ~bank;
            do_write(W'($urandom), 1'($urandom_range(1)));
            stuck = '0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
